// File: rtl/seven_segment_display_scheduler.sv
// Time-shares one hex-to-seven-segment converter across NUM_DIGITS digits and commits them atomically.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits; digit 0 always shows its value.
module seven_segment_display_scheduler #(
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      update_req,
  input  logic [4*NUM_DIGITS-1:0]   value_in,
  output logic                      update_ack,
  output logic                      busy,
  output logic [7*NUM_DIGITS-1:0]   seven_segment_n_o
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);
  localparam logic [6:0] Blank = 7'b1111111;

  typedef enum logic [1:0] {StIdle, StConvert, StCommit} state_e;

  state_e                    state_q;
  logic [IdxW-1:0]           idx_q;
  logic [4*NUM_DIGITS-1:0]   snap_q;
  logic [6:0]                shadow_q [NUM_DIGITS];
  logic                      ack_q;
  logic                      busy_q;
  logic [7*NUM_DIGITS-1:0]   seg_q;

  logic [3:0]                cur_digit;
  logic [6:0]                cur_seg;
  logic [6:0]                wr_seg;
  logic [7*NUM_DIGITS-1:0]   commit_vec;

  assign cur_digit = snap_q[4*idx_q +: 4];

  // The one shared converter; active-low, bit order gfedcba.
  always_comb begin
    cur_seg = Blank;
    case (cur_digit)
      4'h0: cur_seg = 7'b1000000;
      4'h1: cur_seg = 7'b1111001;
      4'h2: cur_seg = 7'b0100100;
      4'h3: cur_seg = 7'b0110000;
      4'h4: cur_seg = 7'b0011001;
      4'h5: cur_seg = 7'b0010010;
      4'h6: cur_seg = 7'b0000010;
      4'h7: cur_seg = 7'b1111000;
      4'h8: cur_seg = 7'b0000000;
      4'h9: cur_seg = 7'b0011000;
      4'hA: cur_seg = 7'b0001000;
      4'hB: cur_seg = 7'b0000011;
      4'hC: cur_seg = 7'b1000110;
      4'hD: cur_seg = 7'b0100001;
      4'hE: cur_seg = 7'b0000110;
      4'hF: cur_seg = 7'b0001110;
      default: cur_seg = Blank;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic seen_nonzero_q;
  logic blank_lead;

  assign blank_lead = !seen_nonzero_q && (cur_digit == 4'h0) && (idx_q != '0);
  assign wr_seg     = blank_lead ? Blank : cur_seg;
`else
  assign wr_seg = cur_seg;
`endif

  // Digit 0 is converted on the same edge that commits, so it bypasses the shadow.
  always_comb begin
    commit_vec = '1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      commit_vec[7*i +: 7] = shadow_q[i];
    end
    commit_vec[6:0] = wr_seg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      snap_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      seg_q   <= '1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        shadow_q[i] <= Blank;
      end
`ifdef LEADING_ZERO_BLANK_EN
      seen_nonzero_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          ack_q <= 1'b0;
          if (update_req) begin
            snap_q  <= value_in;
            idx_q   <= LastIdx;
            busy_q  <= 1'b1;
            state_q <= StConvert;
`ifdef LEADING_ZERO_BLANK_EN
            seen_nonzero_q <= 1'b0;
`endif
          end
        end
        StConvert: begin
          shadow_q[idx_q] <= wr_seg;
`ifdef LEADING_ZERO_BLANK_EN
          if (cur_digit != 4'h0) seen_nonzero_q <= 1'b1;
`endif
          if (idx_q == '0) begin
            seg_q   <= commit_vec;
            ack_q   <= 1'b1;
            state_q <= StCommit;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        StCommit: begin
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign update_ack        = ack_q;
  assign busy              = busy_q;
  assign seven_segment_n_o = seg_q;

endmodule
